pilot_inserter_stream: RTL and testbench
========================================

// Module: pilot_inserter_stream
// PURPOSE
//  Streaming pilot-symbol inserter for the OFDM/SC TX chain. Sits between mapper and pulse shaper.
//  Accepts framed I/Q data symbols over a valid/ready handshake and inserts a pilot symbol
//  before the first data symbol of each frame, then after every N data symbols.
//  Frame size and interval are set at run time; pilots are fixed or PN-polarity-scrambled.
//  Output is registered and flags frame end and pilot beats.
// PARAMETERS
//  DATA_W   32  symbol width; upper half I, lower half Q, two's complement; must be even
//  FRAME_W   8  width of cfg_frame_size (max frame 2^FRAME_W-1 data symbols)
//  INTV_W    4  width of cfg_pilot_interval
//  PN_SEED  7'h7F  LFSR seed, reloaded at every frame start
// PORTS
//  clk                 in   1        system clock, rising edge
//  rst_n               in   1        asynchronous reset, active low
//  cfg_frame_size      in   FRAME_W  data symbols per frame
//  cfg_pilot_interval  in   INTV_W   data symbols between pilots
//  cfg_pn_en           in   1        1: PN-scrambled pilot polarity; 0: fixed pilot
//  pilot_value         in   DATA_W   base pilot symbol
//  err_clr             in   1        pulse: clear error, return to IDLE
//  s_data              in   DATA_W   input data symbol
//  s_valid             in   1        input symbol valid
//  s_ready             out  1        block accepts s_data this cycle
//  m_data              out  DATA_W   output symbol
//  m_valid             out  1        output symbol valid
//  m_ready             in   1        downstream accepts m_data
//  m_last              out  1        last beat of frame (final data symbol)
//  m_pilot             out  1        current beat is a pilot
//  error               out  1        sticky config error
// BEHAVIOUR
//  Reset: every output 0; FSM=IDLE; counters 0; LFSR=PN_SEED.
//  Transfer: occurs on valid&&ready. Output register free = !m_valid || m_ready.
//  s_ready = (state==DATA) && free. Combinational path m_ready->s_ready is permitted.
//  m_valid/m_data/m_last/m_pilot stay stable while m_valid && !m_ready.
//  FSM:
//   IDLE : on s_valid, latch cfg_frame_size/cfg_pilot_interval/cfg_pn_en; reload LFSR.
//          If either latched size is 0 -> ERR, else -> PILOT. No input consumed here.
//   PILOT: when free, load pilot into output reg (m_pilot=1, m_last=0); advance LFSR; -> DATA.
//   DATA : when s_valid && free, load s_data (m_pilot=0); dcnt++, icnt++.
//          Last symbol (dcnt==size-1): m_last=1, -> IDLE.
//          Else if icnt reaches interval: icnt=0, -> PILOT.
//   ERR  : error=1, s_ready=0; outputs already in flight still drain. err_clr -> IDLE, error=0.
//  Config changes mid-frame are ignored until the next IDLE latch.
//  Beats per frame: size + ceil(size/interval). Latency: 1 cycle from input accept to m_valid.
//  No bubble between back-to-back beats when m_ready=1.
//  Exception: IDLE costs 1 cycle per frame.
//  PN: LFSR x^7+x^6+1, shifts once per emitted pilot.
//   If cfg_pn_en && lfsr[0]==1, pilot = both halves negated; otherwise pilot_value.
//   Negating the most-negative value saturates to the max positive.
//  Reset mid-frame: immediate abort; any partial frame is dropped, with no m_last emitted.
// TESTING
//  T1 size=6,intv=2,pn=0, m_ready=1 -> 9 beats P D0 D1 P D2 D3 P D4 D5; m_last only on D5.
//  T2 size=3,intv=4 -> P D0 D1 D2 (one pilot); size=4,intv=1 -> P D0 P D1 P D2 P D3.
//  T3 T1 with m_ready random 50% -> same sequence, no loss/duplication, outputs stable while stalled.
//  T4 size=0 (and separately intv=0) -> error=1 within 2 cycles, s_ready=0;
//     err_clr -> error=0, next valid frame correct.
//  T5 pn=1, pilot_value=32'h4000_4000 -> first pilot 32'hC000_C000 (seed LSB=1);
//     later signs match software LFSR model; pilot 32'h8000_8000 -> 32'h7FFF_7FFF.
//  T6 rst_n low at D3 of T1 -> all outputs 0 immediately;
//     after release, the next frame starts with a pilot and the LFSR is reseeded.

Source files
------------

// File: rtl/pilot_inserter_stream.sv
// pilot_inserter_stream
//   Streaming pilot-symbol inserter between the mapper and the pulse shaper.
//   Framed I/Q data symbols arrive on a valid/ready stream. A pilot symbol is
//   emitted before the first data symbol of each frame and again after every
//   cfg_pilot_interval data symbols. Pilot polarity may be scrambled by a
//   7-bit LFSR (x^7+x^6+1) that is reseeded at every frame start.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cfg_frame_size      data symbols per frame (latched at frame start)
//   cfg_pilot_interval  data symbols between pilots (latched at frame start)
//   cfg_pn_en           1: PN-scrambled pilot polarity, 0: fixed pilot
//   pilot_value         base pilot symbol {I, Q}
//   err_clr             pulse: leave the error state and return to idle
//   s_data/s_valid/s_ready  input symbol stream
//   m_data/m_valid/m_ready  registered output symbol stream
//   m_last              final data symbol of the frame
//   m_pilot             current output beat is a pilot
//   error               sticky configuration error (zero size or interval)
module pilot_inserter_stream #(
  parameter int         DATA_W  = 32,
  parameter int         FRAME_W = 8,
  parameter int         INTV_W  = 4,
  parameter logic [6:0] PN_SEED = 7'h7F
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] cfg_frame_size,
  input  logic [INTV_W-1:0]  cfg_pilot_interval,
  input  logic               cfg_pn_en,
  input  logic [DATA_W-1:0]  pilot_value,
  input  logic               err_clr,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               m_pilot,
  output logic               error
);

  localparam int HALF_W = DATA_W / 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PILOT,
    S_DATA,
    S_ERR
  } state_t;

  // Two's-complement negate of one I or Q half; the most-negative value
  // has no positive counterpart and saturates to the maximum positive.
  function automatic logic [HALF_W-1:0] neg_sat(input logic [HALF_W-1:0] x);
    logic signed [HALF_W-1:0] xs;
    logic signed [HALF_W-1:0] most_neg;
    most_neg = {1'b1, {(HALF_W-1){1'b0}}};
    xs       = signed'(x);
    if (xs == most_neg) begin
      return {1'b0, {(HALF_W-1){1'b1}}};
    end
    return -xs;
  endfunction

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] size_q, size_d;
  logic [INTV_W-1:0]  intv_q, intv_d;
  logic               pn_q, pn_d;
  logic [FRAME_W-1:0] dcnt_q, dcnt_d;
  logic [INTV_W-1:0]  icnt_q, icnt_d;
  logic [6:0]         lfsr_q, lfsr_d;
  logic [DATA_W-1:0]  m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;
  logic               m_last_q, m_last_d;
  logic               m_pilot_q, m_pilot_d;
  logic               error_q, error_d;

  logic               free;
  logic [6:0]         lfsr_next;
  logic [DATA_W-1:0]  pilot_sym;
  logic               last_sym;
  logic               intv_hit;

  // Output register can take a new beat when empty or being drained now.
  assign free      = !m_valid_q || m_ready;
  assign s_ready   = (state_q == S_DATA) && free;

  assign lfsr_next = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
  assign pilot_sym = (pn_q && lfsr_q[0])
                   ? {neg_sat(pilot_value[DATA_W-1:HALF_W]),
                      neg_sat(pilot_value[HALF_W-1:0])}
                   : pilot_value;
  assign last_sym  = (dcnt_q == size_q - FRAME_W'(1));
  assign intv_hit  = ((icnt_q + INTV_W'(1)) == intv_q);

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    intv_d    = intv_q;
    pn_d      = pn_q;
    dcnt_d    = dcnt_q;
    icnt_d    = icnt_q;
    lfsr_d    = lfsr_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_pilot_d = m_pilot_q;
    error_d   = error_q;

    // A beat handed downstream empties the register unless refilled below.
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (s_valid) begin
          size_d = cfg_frame_size;
          intv_d = cfg_pilot_interval;
          pn_d   = cfg_pn_en;
          lfsr_d = PN_SEED;
          dcnt_d = '0;
          icnt_d = '0;
          if ((cfg_frame_size == '0) || (cfg_pilot_interval == '0)) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            state_d = S_PILOT;
          end
        end
      end
      S_PILOT: begin
        if (free) begin
          m_data_d  = pilot_sym;
          m_valid_d = 1'b1;
          m_pilot_d = 1'b1;
          m_last_d  = 1'b0;
          lfsr_d    = lfsr_next;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (s_valid && free) begin
          m_data_d  = s_data;
          m_valid_d = 1'b1;
          m_pilot_d = 1'b0;
          m_last_d  = last_sym;
          dcnt_d    = dcnt_q + FRAME_W'(1);
          if (last_sym) begin
            state_d = S_IDLE;
          end else if (intv_hit) begin
            icnt_d  = '0;
            state_d = S_PILOT;
          end else begin
            icnt_d  = icnt_q + INTV_W'(1);
          end
        end
      end
      S_ERR: begin
        if (err_clr) begin
          error_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output register; reset aborts any partial frame at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      size_q    <= '0;
      intv_q    <= '0;
      pn_q      <= 1'b0;
      dcnt_q    <= '0;
      icnt_q    <= '0;
      lfsr_q    <= PN_SEED;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_pilot_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      intv_q    <= intv_d;
      pn_q      <= pn_d;
      dcnt_q    <= dcnt_d;
      icnt_q    <= icnt_d;
      lfsr_q    <= lfsr_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_pilot_q <= m_pilot_d;
      error_q   <= error_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_pilot = m_pilot_q;
  assign error   = error_q;

endmodule

// File: tb/tb_pilot_inserter_stream.sv
// Testbench for pilot_inserter_stream: scoreboard of expected output beats
// built from a frame model, compared against beats captured on the output.
module tb_pilot_inserter_stream;

  localparam int DW = 32;
  localparam int FW = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] cfg_frame_size = '0;
  logic [IW-1:0] cfg_pilot_interval = '0;
  logic          cfg_pn_en = 1'b0;
  logic [DW-1:0] pilot_value = '0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
  logic          m_pilot;
  logic          error;

  always #5 clk = ~clk;

  pilot_inserter_stream #(
    .DATA_W (DW),
    .FRAME_W(FW),
    .INTV_W (IW),
    .PN_SEED(7'h7F)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg_frame_size    (cfg_frame_size),
    .cfg_pilot_interval(cfg_pilot_interval),
    .cfg_pn_en         (cfg_pn_en),
    .pilot_value       (pilot_value),
    .err_clr           (err_clr),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .m_data            (m_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_last            (m_last),
    .m_pilot           (m_pilot),
    .error             (error)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          pilot;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         obs_q[$];
  int            obs_cyc[$];
  logic [DW-1:0] syms[$];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   rand_mode = 1'b0;
  int   stall_viol = 0;
  logic stall_prev = 1'b0;
  logic [DW+2:0] out_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    m_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Capture every transfer; track output stability across stalled cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev <= 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        obs_q.push_back({m_data, m_last, m_pilot});
        obs_cyc.push_back(cyc);
      end
      if (stall_prev && ({m_valid, m_data, m_last, m_pilot} != out_prev))
        stall_viol <= stall_viol + 1;
      stall_prev <= m_valid && !m_ready;
      out_prev   <= {m_valid, m_data, m_last, m_pilot};
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] neg16(input logic [15:0] x);
    if (x == 16'h8000) return 16'h7FFF;
    return 16'h0000 - x;
  endfunction

  // Reference frame: a pilot precedes data symbol i whenever i is a
  // multiple of the interval; the last data symbol carries m_last.
  task automatic model_frame(input int size, input int intv, input bit pn,
                             input logic [DW-1:0] pv);
    logic [6:0]    l;
    beat_t         b;
    logic [DW-1:0] d;
    l = 7'h7F;
    syms.delete();
    cfg_frame_size     = FW'(size);
    cfg_pilot_interval = IW'(intv);
    cfg_pn_en          = pn;
    pilot_value        = pv;
    for (int i = 0; i < size; i++) begin
      if (i % intv == 0) begin
        b.data  = (pn && l[0]) ? {neg16(pv[31:16]), neg16(pv[15:0])} : pv;
        b.last  = 1'b0;
        b.pilot = 1'b1;
        exp_q.push_back(b);
        l = {l[5:0], l[6] ^ l[5]};
      end
      d = $urandom;
      syms.push_back(d);
      b.data  = d;
      b.last  = (i == size - 1);
      b.pilot = 1'b0;
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_frame(input int nsym, output bit to);
    bit acc;
    int cnt;
    to = 1'b0;
    for (int i = 0; i < nsym && !to; i++) begin
      s_data  = syms[i];
      s_valid = 1'b1;
      acc = 1'b0;
      cnt = 0;
      while (!acc && cnt < 500) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk);
        #1;
        cnt++;
      end
      if (!acc) to = 1'b1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_drain(input int n, output bit ok);
    int cnt;
    cnt = 0;
    while (obs_q.size() < n && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    ok = (obs_q.size() >= n);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_valid, m_data, m_last, m_pilot, error, s_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b_%h_%b%b%b%b required all zero",
               m_valid, m_data, m_last, m_pilot, error, s_ready);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({m_valid, error, s_ready} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset got v/err/rdy=%b%b%b required 000",
               m_valid, error, s_ready);
    end
  endtask

  task automatic test_basic();
    bit    to, ok;
    int    n, span;
    beat_t e, o;
    model_frame(6, 2, 1'b0, 32'h1234_5678);
    n = exp_q.size();
    drive_frame(syms.size(), to);
    wait_drain(n, ok);
    checks++;
    if (to || !ok) begin
      errors++;
      $display("FAIL t1_drain timeout=%0b got=%0d beats required %0d", to, obs_q.size(), n);
    end
    span = (obs_cyc.size() >= 9) ? (obs_cyc[8] - obs_cyc[0]) : -1;
    checks++;
    if (span != 8) begin
      errors++;
      $display("FAIL t1_back_to_back span=%0d cycles required 8", span);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL t1_beat got=%h/%b/%b required %h/%b/%b",
                 o.data, o.last, o.pilot, e.data, e.last, e.pilot);
      end
    end
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL t1_count extra_obs=%0d missing=%0d required 0/0", obs_q.size(), exp_q.size());
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_intervals();
    bit    to, ok;
    int    n;
    beat_t e, o;
    int    sizes[4] = '{3, 4, 1, 255};
    int    intvs[4] = '{4, 1, 1, 15};
    for (int f = 0; f < 4; f++) begin
      model_frame(sizes[f], intvs[f], 1'b0, 32'h0F0F_F0F0 + f);
      n = exp_q.size();
      drive_frame(syms.size(), to);
      wait_drain(n, ok);
      checks++;
      if (to || !ok) begin
        errors++;
        $display("FAIL t2_drain frame=%0d got=%0d beats required %0d", f, obs_q.size(), n);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL t2_beat frame=%0d got=%h/%b/%b required %h/%b/%b",
                   f, o.data, o.last, o.pilot, e.data, e.last, e.pilot);
        end
      end
      checks++;
      if (obs_q.size() != 0 || exp_q.size() != 0) begin
        errors++;
        $display("FAIL t2_count frame=%0d extra_obs=%0d missing=%0d required 0/0",
                 f, obs_q.size(), exp_q.size());
      end
      exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    end
  endtask

  task automatic test_backpressure();
    bit    to, ok;
    int    n, base;
    beat_t e, o;
    int    sizes[3] = '{6, 6, 5};
    int    intvs[3] = '{2, 2, 3};
    base = stall_viol;
    rand_mode = 1'b1;
    for (int f = 0; f < 3; f++) begin
      model_frame(sizes[f], intvs[f], 1'b0, 32'hA5A5_5A5A);
      drive_frame(syms.size(), to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL t3_input_timeout frame=%0d got=1 required 0", f);
      end
    end
    n = exp_q.size();
    wait_drain(n, ok);
    rand_mode = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL t3_drain got=%0d beats required %0d", obs_q.size(), n);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL t3_beat got=%h/%b/%b required %h/%b/%b",
                 o.data, o.last, o.pilot, e.data, e.last, e.pilot);
      end
    end
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL t3_count extra_obs=%0d missing=%0d required 0/0", obs_q.size(), exp_q.size());
    end
    checks++;
    if (stall_viol - base != 0) begin
      errors++;
      $display("FAIL t3_stall_stability changes=%0d required 0", stall_viol - base);
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_error();
    bit    to, ok;
    int    n;
    beat_t e, o;
    int    bad_size[2] = '{0, 5};
    int    bad_intv[2] = '{2, 0};
    for (int k = 0; k < 2; k++) begin
      cfg_frame_size     = FW'(bad_size[k]);
      cfg_pilot_interval = IW'(bad_intv[k]);
      s_data  = 32'hDEAD_BEEF;
      s_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({error, s_ready, m_valid} !== 3'b100) begin
        errors++;
        $display("FAIL t4_error_set case=%0d got err/rdy/v=%b%b%b required 100",
                 k, error, s_ready, m_valid);
      end
      s_valid = 1'b0;
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      checks++;
      if (error !== 1'b0) begin
        errors++;
        $display("FAIL t4_error_clr case=%0d got=%b required 0", k, error);
      end
    end
    model_frame(4, 2, 1'b0, 32'h0001_FFFF);
    n = exp_q.size();
    drive_frame(syms.size(), to);
    wait_drain(n, ok);
    checks++;
    if (to || !ok) begin
      errors++;
      $display("FAIL t4_drain got=%0d beats required %0d", obs_q.size(), n);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL t4_beat got=%h/%b/%b required %h/%b/%b",
                 o.data, o.last, o.pilot, e.data, e.last, e.pilot);
      end
    end
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL t4_count extra_obs=%0d missing=%0d required 0/0", obs_q.size(), exp_q.size());
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_pn();
    bit            to, ok;
    int            n;
    beat_t         e, o;
    logic [DW-1:0] first;
    logic [DW-1:0] pvs[2]   = '{32'h4000_4000, 32'h8000_8000};
    logic [DW-1:0] firsts[2] = '{32'hC000_C000, 32'h7FFF_7FFF};
    int            sizes[2] = '{20, 3};
    int            intvs[2] = '{2, 1};
    for (int f = 0; f < 2; f++) begin
      model_frame(sizes[f], intvs[f], 1'b1, pvs[f]);
      n = exp_q.size();
      drive_frame(syms.size(), to);
      wait_drain(n, ok);
      checks++;
      if (to || !ok) begin
        errors++;
        $display("FAIL t5_drain frame=%0d got=%0d beats required %0d", f, obs_q.size(), n);
      end
      first = (obs_q.size() > 0) ? obs_q[0].data : 'x;
      checks++;
      if (first !== firsts[f]) begin
        errors++;
        $display("FAIL t5_first_pilot frame=%0d got=%h required %h", f, first, firsts[f]);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL t5_beat frame=%0d got=%h/%b/%b required %h/%b/%b",
                   f, o.data, o.last, o.pilot, e.data, e.last, e.pilot);
        end
      end
      checks++;
      if (obs_q.size() != 0 || exp_q.size() != 0) begin
        errors++;
        $display("FAIL t5_count frame=%0d extra_obs=%0d missing=%0d required 0/0",
                 f, obs_q.size(), exp_q.size());
      end
      exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    end
  endtask

  task automatic test_reset_midframe();
    bit            to, ok;
    int            n;
    beat_t         e, o;
    logic [DW-1:0] first;
    // Abort right after D3 is loaded: P D0 D1 P D2 have left, D3 is held.
    model_frame(6, 2, 1'b0, 32'h1111_2222);
    drive_frame(4, to);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_data, m_last, m_pilot, error, s_ready} !== '0) begin
      errors++;
      $display("FAIL t6_reset_outputs got=%b_%h_%b%b%b%b required all zero",
               m_valid, m_data, m_last, m_pilot, error, s_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (to || obs_q.size() != 5) begin
      errors++;
      $display("FAIL t6_partial_beats got=%0d required 5", obs_q.size());
    end
    for (int k = 0; k < 5 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL t6_partial_beat got=%h/%b/%b required %h/%b/%b",
                 o.data, o.last, o.pilot, e.data, e.last, e.pilot);
      end
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_frame(6, 2, 1'b1, 32'h4000_4000);
    n = exp_q.size();
    drive_frame(syms.size(), to);
    wait_drain(n, ok);
    checks++;
    if (to || !ok) begin
      errors++;
      $display("FAIL t6_drain got=%0d beats required %0d", obs_q.size(), n);
    end
    first = (obs_q.size() > 0) ? obs_q[0].data : 'x;
    checks++;
    if (first !== 32'hC000_C000) begin
      errors++;
      $display("FAIL t6_reseed_pilot got=%h required c000c000", first);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL t6_beat got=%h/%b/%b required %h/%b/%b",
                 o.data, o.last, o.pilot, e.data, e.last, e.pilot);
      end
    end
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL t6_count extra_obs=%0d missing=%0d required 0/0", obs_q.size(), exp_q.size());
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_intervals();
    test_backpressure();
    test_error();
    test_pn();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
